// File: rtl/multicore_pio_gen_if.sv
// Avalon-MM slave bus bundle for multicore_pio_gen: word address, chip select,
// active-low write strobe, 32-bit write data and combinational 32-bit read data.
interface multicore_pio_gen_if;
    // Handshake: a write happens on any clk edge where chipselect=1 and write_n=0;
    // reads have no wait states, so readdata is valid whenever address is stable.
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/multicore_pio_gen.sv
// Parametrised GPIO with per-bit direction, synchronised inputs, edge capture and masked IRQ.
// Define PIO_BITSET_EN to add the OUTSET (addr 4) and OUTCLR (addr 5) write-only registers.
module multicore_pio_gen #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    EDGE_TYPE   = 0,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    multicore_pio_gen_if.slave    bus,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe,
    output logic                  irq
);

    localparam logic [2:0] PRIME_CNT = 3'(SYNC_STAGES + 1);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] dir_q, dir_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] edge_q, edge_d;
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
    logic [DATA_WIDTH-1:0] in_prev_q;
    logic [2:0]            prime_q, prime_d;
    logic                  irq_q, irq_d;

    logic                  wr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] in_sync;
    logic [DATA_WIDTH-1:0] edge_hit;
    logic [DATA_WIDTH-1:0] edge_set;
    logic                  prime_done;
    logic                  unused_wdata;

    assign wr           = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[DATA_WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;
    assign in_sync      = sync_q[SYNC_STAGES-1];
    assign sync_d       = {sync_q[SYNC_STAGES-2:0], in_port};
    assign prime_done   = (prime_q == PRIME_CNT);
    assign prime_d      = prime_done ? prime_q : prime_q + 3'd1;

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_hit = in_sync & ~in_prev_q;
            1:       edge_hit = ~in_sync & in_prev_q;
            default: edge_hit = in_sync ^ in_prev_q;
        endcase
    end

    // Edges are ignored until the synchroniser and in_prev have filled with real input.
    assign edge_set = prime_done ? edge_hit : '0;

    always_comb begin
        data_d = data_q;
        if (wr && bus.address == 3'd0) data_d = wdata;
`ifdef PIO_BITSET_EN
        else if (wr && bus.address == 3'd4) data_d = data_q | wdata;
        else if (wr && bus.address == 3'd5) data_d = data_q & ~wdata;
`endif
    end

    always_comb begin
        dir_d  = (wr && bus.address == 3'd1) ? wdata : dir_q;
        mask_d = (wr && bus.address == 3'd2) ? wdata : mask_q;
        // A new edge on a bit being cleared in the same cycle keeps the bit set.
        edge_d = edge_set | ((wr && bus.address == 3'd3) ? (edge_q & ~wdata) : edge_q);
        irq_d  = |(edge_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q    <= RESET_VALUE;
            dir_q     <= '0;
            mask_q    <= '0;
            edge_q    <= '0;
            sync_q    <= '0;
            in_prev_q <= '0;
            prime_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            data_q    <= data_d;
            dir_q     <= dir_d;
            mask_q    <= mask_d;
            edge_q    <= edge_d;
            sync_q    <= sync_d;
            in_prev_q <= in_sync;
            prime_q   <= prime_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            3'd0:    bus.readdata[DATA_WIDTH-1:0] = (data_q & dir_q) | (in_sync & ~dir_q);
            3'd1:    bus.readdata[DATA_WIDTH-1:0] = dir_q;
            3'd2:    bus.readdata[DATA_WIDTH-1:0] = mask_q;
            3'd3:    bus.readdata[DATA_WIDTH-1:0] = edge_q;
            default: bus.readdata = '0;
        endcase
    end

    assign out_port = data_q;
    assign oe       = dir_q;
    assign irq      = irq_q;

endmodule
